// File: rtl/phase_sequencer_if.sv
// rtl/phase_sequencer_if.sv - run-control and phase bundle between the sequencer and its controller
interface phase_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic             halt;
    logic [2:0]       last_phase;
    logic             mem_req;
    logic             mem_ready;
    logic             alu_busy;
    logic             step_mode;
    logic             step;
    logic [7:0]       T;
    logic             busy;
    logic             halted;
    logic             fault;
    logic             instr_done;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        output run, halt, last_phase, mem_req, mem_ready, alu_busy, step_mode, step,
        input  T, busy, halted, fault, instr_done, cycle_cnt, instr_cnt
    );

    modport slave (
        input  run, halt, last_phase, mem_req, mem_ready, alu_busy, step_mode, step,
        output T, busy, halted, fault, instr_done, cycle_cnt, instr_cnt
    );
endinterface

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - one-hot timing-phase generator and run-control FSM for the 8-bit CPU
module phase_sequencer #(
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    phase_sequencer_if.slave      bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_HALTED,
        S_FAULT
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t           state_q, state_d;
    logic [2:0]       ph_q, ph_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] instr_q, instr_d;
    logic             done_q, done_d;
    logic             stall;
    logic [2:0]       end_ph;

    // Short encodings still run the fetch phases T0..T3.
    assign end_ph = (bus.last_phase < 3'd3) ? 3'd3 : bus.last_phase;
    assign stall  = (bus.mem_req & ~bus.mem_ready) | ((ph_q == 3'd6) & bus.alu_busy);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ph_q    <= 3'd0;
            wait_q  <= 8'd0;
            cycle_q <= '0;
            instr_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            wait_q  <= wait_d;
            cycle_q <= cycle_d;
            instr_q <= instr_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        wait_d  = 8'd0;
        cycle_d = cycle_q;
        instr_d = instr_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.run) begin
                    state_d = S_RUN;
                    ph_d    = 3'd0;
                end
            end
            S_RUN: begin
                cycle_d = cycle_q + CNT_W'(1);
                if (stall) begin
                    if (wait_q == WAIT_LAST) begin
                        state_d = S_FAULT;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end else if (ph_q < end_ph) begin
                    ph_d = ph_q + 3'd1;
                end else begin
                    instr_d = instr_q + CNT_W'(1);
                    done_d  = 1'b1;
                    ph_d    = 3'd0;
                    // Completion exits are prioritised: HLT beats single-step beats run-off.
                    if (bus.halt) begin
                        state_d = S_HALTED;
                    end else if (bus.step_mode) begin
                        state_d = S_PAUSE;
                    end else if (!bus.run) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_PAUSE: begin
                if (!bus.run) begin
                    state_d = S_IDLE;
                end else if (bus.step || !bus.step_mode) begin
                    state_d = S_RUN;
                    ph_d    = 3'd0;
                end
            end
            S_HALTED: state_d = S_HALTED;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_IDLE;
        endcase
    end

    assign bus.T          = (state_q == S_RUN) ? (8'd1 << ph_q) : 8'd0;
    assign bus.busy       = (state_q == S_RUN);
    assign bus.halted     = (state_q == S_HALTED);
    assign bus.fault      = (state_q == S_FAULT);
    assign bus.instr_done = done_q;
    assign bus.cycle_cnt  = cycle_q;
    assign bus.instr_cnt  = instr_q;
endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - directed bench for phase_sequencer
module tb_phase_sequencer;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    phase_sequencer_if #(.CNT_W(16)) bus ();

    phase_sequencer #(
        .CNT_W    (16),
        .WAIT_MAX (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        rst            = 1'b1;
        bus.run        = 1'b0;
        bus.halt       = 1'b0;
        bus.last_phase = 3'd0;
        bus.mem_req    = 1'b0;
        bus.mem_ready  = 1'b0;
        bus.alu_busy   = 1'b0;
        bus.step_mode  = 1'b0;
        bus.step       = 1'b0;
        tick();
        tick();
        check("rst_T",      32'(bus.T), 0);
        check("rst_busy",   32'(bus.busy), 0);
        check("rst_halted", 32'(bus.halted), 0);
        check("rst_fault",  32'(bus.fault), 0);
        check("rst_done",   32'(bus.instr_done), 0);
        check("rst_cycle",  32'(bus.cycle_cnt), 0);
        check("rst_instr",  32'(bus.instr_cnt), 0);

        // Full-length instructions: T0..T7 twice, then the third T0.
        rst            = 1'b0;
        bus.run        = 1'b1;
        bus.last_phase = 3'd7;
        tick();
        for (int i = 0; i < 16; i++) begin
            check("full_T",    32'(bus.T), 1 << (i % 8));
            check("full_done", 32'(bus.instr_done), (i == 8) ? 1 : 0);
            tick();
        end
        check("full_T_wrap", 32'(bus.T), 1);
        check("full_done2",  32'(bus.instr_done), 1);
        check("full_instr",  32'(bus.instr_cnt), 2);
        check("full_cycle",  32'(bus.cycle_cnt), 16);

        // Short instruction of five phases.
        bus.last_phase = 3'd4;
        for (int i = 0; i < 10; i++) begin
            check("short4_T", 32'(bus.T), 1 << (i % 5));
            tick();
        end
        // last_phase below 3 still runs to T3.
        bus.last_phase = 3'd1;
        for (int i = 0; i < 8; i++) begin
            check("short1_T", 32'(bus.T), 1 << (i % 4));
            tick();
        end
        check("short_instr", 32'(bus.instr_cnt), 6);
        check("short_cycle", 32'(bus.cycle_cnt), 34);

        // Memory stall in T2 for three cycles.
        bus.last_phase = 3'd7;
        tick();
        tick();
        check("mem_cycle0", 32'(bus.cycle_cnt), 36);
        bus.mem_req   = 1'b1;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("mem_T_hold", 32'(bus.T), 8'h04);
            tick();
        end
        bus.mem_ready = 1'b1;
        check("mem_T_last", 32'(bus.T), 8'h04);
        tick();
        bus.mem_req   = 1'b0;
        bus.mem_ready = 1'b0;
        check("mem_T_next", 32'(bus.T), 8'h08);
        check("mem_cycle",  32'(bus.cycle_cnt), 40);

        // Watchdog: ALU busy held in T6 until FAULT.
        tick();
        tick();
        tick();
        bus.alu_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("wd_T_hold", 32'(bus.T), 8'h40);
            tick();
        end
        check("wd_T",     32'(bus.T), 0);
        check("wd_fault", 32'(bus.fault), 1);
        check("wd_busy",  32'(bus.busy), 0);
        bus.alu_busy = 1'b0;
        tick();
        check("wd_fault_stay", 32'(bus.fault), 1);
        check("wd_T_stay",     32'(bus.T), 0);
        check("wd_cycle",      32'(bus.cycle_cnt), 47);
        bus.run = 1'b0;
        rst     = 1'b1;
        #1;
        check("wd_rst_fault", 32'(bus.fault), 0);
        check("wd_rst_cycle", 32'(bus.cycle_cnt), 0);
        tick();
        rst = 1'b0;
        tick();
        check("wd_idle_T", 32'(bus.T), 0);

        // HLT at the end of a four-phase instruction.
        bus.run        = 1'b1;
        bus.last_phase = 3'd3;
        tick();
        tick();
        tick();
        tick();
        check("hlt_T3", 32'(bus.T), 8'h08);
        bus.halt = 1'b1;
        tick();
        check("hlt_halted", 32'(bus.halted), 1);
        check("hlt_T",      32'(bus.T), 0);
        check("hlt_done",   32'(bus.instr_done), 1);
        check("hlt_instr",  32'(bus.instr_cnt), 1);
        bus.halt = 1'b0;
        bus.run  = 1'b0;
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        bus.run  = 1'b1;
        tick();
        check("hlt_stay",      32'(bus.halted), 1);
        check("hlt_stay_T",    32'(bus.T), 0);
        check("hlt_stay_busy", 32'(bus.busy), 0);
        check("hlt_stay_done", 32'(bus.instr_done), 0);

        // Single-step, then halt taking priority over step_mode.
        rst = 1'b1;
        tick();
        rst           = 1'b0;
        bus.step_mode = 1'b1;
        tick();
        check("ss_T0", 32'(bus.T), 8'h01);
        tick();
        tick();
        tick();
        check("ss_T3", 32'(bus.T), 8'h08);
        tick();
        check("ss_pause_T",    32'(bus.T), 0);
        check("ss_pause_busy", 32'(bus.busy), 0);
        check("ss_pause_done", 32'(bus.instr_done), 1);
        tick();
        check("ss_pause_hold", 32'(bus.T), 0);
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        check("ss_step_T", 32'(bus.T), 8'h01);
        tick();
        tick();
        tick();
        check("ss_T3b", 32'(bus.T), 8'h08);
        bus.halt = 1'b1;
        tick();
        check("ss_prio_halted", 32'(bus.halted), 1);
        check("ss_prio_busy",   32'(bus.busy), 0);
        check("ss_prio_instr",  32'(bus.instr_cnt), 2);
        bus.halt = 1'b0;

        // Asynchronous reset in the middle of an instruction.
        rst = 1'b1;
        tick();
        rst           = 1'b0;
        bus.step_mode = 1'b0;
        tick();
        tick();
        tick();
        check("ar_T_before", 32'(bus.T), 8'h04);
        #2;
        rst = 1'b1;
        #1;
        check("ar_T",     32'(bus.T), 0);
        check("ar_busy",  32'(bus.busy), 0);
        check("ar_cycle", 32'(bus.cycle_cnt), 0);
        tick();
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
